// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory port sequencer
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } mem_state_e;

    // Upper address byte selects the region: zero is block RAM, anything else cellular RAM
    localparam int CELL_SEL_HI    = 23;
    localparam int CELL_SEL_LO    = 16;

    localparam int DEF_BLOCK_WAIT = 2;
    localparam int DEF_CELL_WAIT  = 8;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - loadable down-counter with zero flag, saturates at zero
module mem_wait_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - single-beat CPU to memory_manager port sequencer; MEM_CELL_EN enables cellular accesses
module mem_port_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int BLOCK_WAIT = DEF_BLOCK_WAIT,
    parameter int CELL_WAIT  = DEF_CELL_WAIT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              mem_req,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (CELL_WAIT > 1) ? $clog2(CELL_WAIT) : 1;
    localparam logic [CNT_W-1:0] BLOCK_LOAD = CNT_W'(BLOCK_WAIT - 1);
`ifdef MEM_CELL_EN
    localparam logic [CNT_W-1:0] CELL_LOAD  = CNT_W'(CELL_WAIT - 1);
`endif

    mem_state_e        state_q, state_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              cpu_done_q, cpu_done_d;
    logic              cpu_err_q, cpu_err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              we_q, we_d;

    logic              is_cell;
    logic              reject;
    logic [CNT_W-1:0]  wait_val;
    logic              tmr_load, tmr_dec, tmr_zero;

    assign is_cell = (cpu_addr[CELL_SEL_HI:CELL_SEL_LO] != '0);

    always_comb begin
`ifdef MEM_CELL_EN
        reject   = 1'b0;
        wait_val = is_cell ? CELL_LOAD : BLOCK_LOAD;
`else
        reject   = is_cell;
        wait_val = BLOCK_LOAD;
`endif
    end

    mem_wait_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load_i  (tmr_load),
        .value_i (wait_val),
        .dec_i   (tmr_dec),
        .zero_o  (tmr_zero)
    );

    // Every output is the registered image of its _d value, so done/err are raised on the edge entering CAPTURE
    always_comb begin
        state_d     = state_q;
        cpu_ready_d = cpu_ready_q;
        cpu_done_d  = 1'b0;
        cpu_err_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_rw_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        we_d        = we_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_valid && cpu_ready_q) begin
                    cpu_ready_d = 1'b0;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    we_d        = cpu_we;
                    if (reject) begin
                        state_d     = CAPTURE;
                        cpu_done_d  = 1'b1;
                        cpu_err_d   = 1'b1;
                        cpu_rdata_d = '0;
                    end else begin
                        state_d   = ACCESS;
                        mem_req_d = 1'b1;
                        mem_rw_d  = cpu_we;
                        tmr_load  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    state_d    = CAPTURE;
                    mem_req_d  = 1'b0;
                    cpu_done_d = 1'b1;
                    if (!we_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
                end
            end
            CAPTURE: begin
                state_d     = IDLE;
                cpu_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                cpu_ready_d = 1'b1;
                mem_req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cpu_ready_q <= 1'b1;
            cpu_done_q  <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_done_q  <= cpu_done_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            we_q        <= we_d;
        end
    end

    assign cpu_ready      = cpu_ready_q;
    assign cpu_done       = cpu_done_q;
    assign cpu_err        = cpu_err_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign mem_req        = mem_req_q;
    assign mem_read_write = mem_rw_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule
